if_id_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register of the MIPS core. Owns the PC and

---
 rtl/mips_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 39 +++
 rtl/if_id_stage.sv | 209 ++++++++++++++++++++
 tb/tb_if_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction field layout and fetch FSM states.
package mips_pkg;

    // Field widths
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;

    // Field LSB positions within the 32-bit instruction word
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned TGT_LSB   = 0;

    // All-zero word decodes as sll $0,$0,0, i.e. a NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word (instr + pc4) that arrived while ID was stalled.
module fetch_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [31:0]  in_instr,
    input  logic [W-1:0] in_pc4,
    output logic         valid,
    output logic [31:0]  instr,
    output logic [W-1:0] pc4
);

    logic         valid_q;
    logic [31:0]  instr_q;
    logic [W-1:0] pc4_q;

    // Capture on load, empty on clear; clear wins if both are ever raised together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= in_instr;
            pc4_q   <= in_pc4;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch (single-outstanding req/ack) plus the IF/ID pipeline register.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_stall_cycles counters.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc4,
    output logic [OPC_W-1:0]  id_opcode,
    output logic [REG_W-1:0]  id_rs,
    output logic [REG_W-1:0]  id_rt,
    output logic [REG_W-1:0]  id_rd,
    output logic [REG_W-1:0]  id_shamt,
    output logic [FUNCT_W-1:0] id_funct,
    output logic [IMM_W-1:0]  id_imm16,
    output logic [TGT_W-1:0]  id_target26
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;       // address of the next/current fetch
    logic [ADDR_W-1:0] addr_q, addr_d;   // address of the request on the bus, frozen until ack
    logic              discard_q, discard_d;
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;

    logic              accept;     // returned word is kept (pc advances)
    logic              launch;     // a new request starts next cycle
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;
    logic              ifid_fetched;

    fetch_skid_buf #(
        .W (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_instr (imem_rdata),
        .in_pc4   (addr_q + PC_STEP),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc4      (skid_pc4)
    );

    // Fetch FSM next state, PC, bus address and discard tracking
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        accept     = 1'b0;
        launch     = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                launch  = 1'b1;
            end
            StReq: begin
                if (imem_ack) begin
                    discard_d = 1'b0;
                    launch    = 1'b1;
                    // A word already orphaned by a redirect, or racing one, is dropped
                    if (!discard_q && !redirect_valid) begin
                        accept = 1'b1;
                        pc_d   = pc_q + PC_STEP;
                        if (stall && !flush) begin
                            skid_load = 1'b1;
                            state_d   = StHold;
                            launch    = 1'b0;
                        end
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (flush || !stall) begin
                    skid_clear = 1'b1;
                    state_d    = StReq;
                    launch     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end
        if (launch) begin
            addr_d = pc_d;
        end
    end

    // IF/ID register next state: flush beats stall, stall holds, otherwise load or bubble
    always_comb begin
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        ifid_fetched = 1'b0;
        if (flush) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (state_q == StHold && skid_valid) begin
                id_valid_d   = 1'b1;
                id_instr_d   = skid_instr;
                id_pc4_d     = skid_pc4;
                ifid_fetched = 1'b1;
            end else if (accept) begin
                id_valid_d   = 1'b1;
                id_instr_d   = imem_rdata;
                id_pc4_d     = addr_q + PC_STEP;
                ifid_fetched = 1'b1;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        end
    end

    // Fetch and IF/ID state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    assign imem_req  = (state_q == StReq);
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;

    assign id_opcode   = id_instr_q[OPC_LSB +: OPC_W];
    assign id_rs       = id_instr_q[RS_LSB +: REG_W];
    assign id_rt       = id_instr_q[RT_LSB +: REG_W];
    assign id_rd       = id_instr_q[RD_LSB +: REG_W];
    assign id_shamt    = id_instr_q[SHAMT_LSB +: REG_W];
    assign id_funct    = id_instr_q[FUNCT_LSB +: FUNCT_W];
    assign id_imm16    = id_instr_q[IMM_LSB +: IMM_W];
    assign id_target26 = id_instr_q[TGT_LSB +: TGT_W];

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_stall_q;

    // Free-running wrap-around counters of IF/ID loads and stalled live cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (ifid_fetched) begin
                stat_fetched_q <= stat_fetched_q + 32'd1;
            end
            if (stall && id_valid_q) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched      = stat_fetched_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    logic unused_fetched;
    assign unused_fetched = ifid_fetched;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: decode-field table plus stall/redirect/flush/wrap/reset
// sequences. Stats counters are checked when built with FETCH_STATS_EN.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_target26;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall_cycles;
`endif

    if_id_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc4         (id_pc4),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_funct       (id_funct),
        .id_imm16       (id_imm16),
        .id_target26    (id_target26)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    // Downstream sign_extend unit fed by id_imm16
    logic [31:0] sext_out;
    assign sext_out = {{16{id_imm16[15]}}, id_imm16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  opc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] sext;
    } vec_t;

    vec_t tbl [5];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: wait (bounded) for a request, ack it for one cycle, check IF/ID
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        check("fetch_id_valid", 32'(id_valid), 32'd1);
        check("fetch_id_instr", id_instr, word);
        check("fetch_id_pc4", id_pc4, exp_addr + 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h2008FF85, 6'h08, 5'd0, 5'd8,  5'd31, 5'd30, 6'h05, 16'hFF85,
                   26'h008FF85, 32'hFFFFFF85};
        tbl[1] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020,
                   26'h12A4020, 32'h00004020};
        tbl[2] = '{32'h08100040, 6'h02, 5'd0, 5'd16, 5'd0,  5'd1,  6'h00, 16'h0040,
                   26'h0100040, 32'h00000040};
        tbl[3] = '{32'hFFFFFFFF, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF,
                   26'h3FFFFFF, 32'hFFFFFFFF};
        tbl[4] = '{32'h8C880004, 6'h23, 5'd4, 5'd8,  5'd0,  5'd0,  6'h04, 16'h0004,
                   26'h0880004, 32'h00000004};

        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_opcode", 32'(id_opcode), 32'h0);
        check("rst_imm16", 32'(id_imm16), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Back-to-back fetches with field decode
        for (int i = 0; i < 5; i++) begin
            do_fetch(tbl[i].instr, 32'(i * 4));
            check("opcode", 32'(id_opcode), 32'(tbl[i].opc));
            check("rs", 32'(id_rs), 32'(tbl[i].rs));
            check("rt", 32'(id_rt), 32'(tbl[i].rt));
            check("rd", 32'(id_rd), 32'(tbl[i].rd));
            check("shamt", 32'(id_shamt), 32'(tbl[i].sh));
            check("funct", 32'(id_funct), 32'(tbl[i].fn));
            check("imm16", 32'(id_imm16), 32'(tbl[i].imm));
            check("target26", 32'(id_target26), 32'(tbl[i].tgt));
            check("sext", sext_out, tbl[i].sext);
        end

        // Ack while stalled: word parks in the skid, IF/ID holds for 3 stalled cycles
        check("stall_addr", imem_addr, 32'd20);
        imem_ack   = 1'b1;
        imem_rdata = 32'h11111111;
        stall      = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_instr", id_instr, 32'h8C880004);
            check("hold_valid", 32'(id_valid), 32'd1);
            if (k < 2) @(negedge clk);
        end
        stall = 1'b0;
        @(negedge clk);
        check("skid_instr", id_instr, 32'h11111111);
        check("skid_pc4", id_pc4, 32'd24);
        check("skid_valid", 32'(id_valid), 32'd1);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'd24);

        // Redirect while the request is pending; its ack arrives 2 cycles later and is dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0102;
        flush          = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        flush          = 1'b0;
        check("redir_valid", 32'(id_valid), 32'd0);
        check("redir_instr", id_instr, 32'h0);
        check("redir_addr_hold", imem_addr, 32'd24);
        @(negedge clk);
        check("redir_addr_hold2", imem_addr, 32'd24);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("drop_valid", 32'(id_valid), 32'd0);
        check("drop_instr", id_instr, 32'h0);
        check("redir_new_addr", imem_addr, 32'h0040_0100);
        do_fetch(tbl[1].instr, 32'h0040_0100);

        // Flush and stall together: flush wins
        stall = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        check("flush_stall_valid", 32'(id_valid), 32'd0);
        check("flush_stall_instr", id_instr, 32'h0);
        check("flush_keep_addr", imem_addr, 32'h0040_0104);

        // Redirect with ack in the same cycle, to the top of memory; PC then wraps
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        flush          = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hCAFEF00D;
        @(negedge clk);
        redirect_valid = 1'b0;
        flush          = 1'b0;
        imem_ack       = 1'b0;
        check("same_cyc_drop", 32'(id_valid), 32'd0);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(tbl[3].instr, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset asserted mid-request, then a stray ack while idle
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_valid", 32'(id_valid), 32'd0);
        check("mid_rst_instr", id_instr, 32'h0);
        check("mid_rst_pc4", id_pc4, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("stray_valid", 32'(id_valid), 32'd0);
        check("stray_req", 32'(imem_req), 32'd1);
        check("stray_addr", imem_addr, 32'h0);

        // Ten fetches with a 4-cycle stall on a live instruction in the middle
        for (int i = 0; i < 5; i++) begin
            do_fetch(tbl[i].instr, 32'(i * 4));
        end
        stall = 1'b1;
        repeat (4) @(negedge clk);
        stall = 1'b0;
        check("stall_noack_valid", 32'(id_valid), 32'd1);
        check("stall_noack_instr", id_instr, 32'h8C880004);
        for (int i = 0; i < 5; i++) begin
            do_fetch(tbl[i].instr, 32'(20 + i * 4));
        end
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, 32'd10);
        check("stat_stall_cycles", stat_stall_cycles, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
